// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_port_arbiter.
// master = arbiter side, slave = fetch/LSU/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            if_req_valid;
    logic            if_req_ready;
    logic [AW-1:0]   if_req_addr;
    logic            if_rsp_valid;
    logic [DW-1:0]   if_rsp_rdata;

    logic            ls_req_valid;
    logic            ls_req_ready;
    logic [AW-1:0]   ls_req_addr;
    logic            ls_req_we;
    logic [DW-1:0]   ls_req_wdata;
    logic [DW/8-1:0] ls_req_wstrb;
    logic            ls_rsp_valid;
    logic [DW-1:0]   ls_rsp_rdata;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_req_we;
    logic [DW-1:0]   mem_req_wdata;
    logic [DW/8-1:0] mem_req_wstrb;
    logic            mem_rsp_valid;
    logic [DW-1:0]   mem_rsp_rdata;

    logic            busy;

    modport master (
        input  if_req_valid, if_req_addr,
        input  ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata,
        output ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
        output busy
    );

    modport slave (
        output if_req_valid, if_req_addr,
        output ls_req_valid, ls_req_addr, ls_req_we, ls_req_wdata, ls_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (IF) and LSU (LS).
// Define ARB_RR_EN for round-robin tie breaking; default is fixed priority with LS winning.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [1:0]      state;
    logic            owner;
    logic            last_grant;
    logic            grant_if;
    logic            grant_ls;
    logic            accept;

    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;

    logic            if_rsp_vld_p1;
    logic            ls_rsp_vld_p1;
    logic [DW-1:0]   if_rdata_p1;
    logic [DW-1:0]   ls_rdata_p1;

    // Grants only exist in IDLE, so both readys drop as soon as a transaction starts
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == S_IDLE) begin
`ifdef ARB_RR_EN
            if (bus.if_req_valid && bus.ls_req_valid) begin
                grant_ls = (last_grant == OWN_IF);
                grant_if = (last_grant == OWN_LS);
            end else begin
                grant_ls = bus.ls_req_valid;
                grant_if = bus.if_req_valid;
            end
`else
            grant_ls = bus.ls_req_valid;
            grant_if = bus.if_req_valid && !bus.ls_req_valid;
`endif
        end
    end

    assign accept = grant_if || grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            owner         <= OWN_IF;
            last_grant    <= OWN_IF;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            if_rsp_vld_p1 <= 1'b0;
            ls_rsp_vld_p1 <= 1'b0;
            if_rdata_p1   <= '0;
            ls_rdata_p1   <= '0;
        end else begin
            if_rsp_vld_p1 <= 1'b0;
            ls_rsp_vld_p1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_REQ;
                        owner      <= grant_ls ? OWN_LS : OWN_IF;
                        last_grant <= grant_ls ? OWN_LS : OWN_IF;
                        addr_q     <= grant_ls ? bus.ls_req_addr : bus.if_req_addr;
                        // Fetches are always plain reads with no write payload
                        we_q       <= grant_ls && bus.ls_req_we;
                        wdata_q    <= grant_ls ? bus.ls_req_wdata : '0;
                        wstrb_q    <= grant_ls ? bus.ls_req_wstrb : '0;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    // Response stage: one-cycle pulse to the owner only
                    if (bus.mem_rsp_valid) begin
                        state <= S_IDLE;
                        if (owner == OWN_LS) begin
                            ls_rsp_vld_p1 <= 1'b1;
                            ls_rdata_p1   <= bus.mem_rsp_rdata;
                        end else begin
                            if_rsp_vld_p1 <= 1'b1;
                            if_rdata_p1   <= bus.mem_rsp_rdata;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_req_ready  = grant_if;
    assign bus.ls_req_ready  = grant_ls;
    assign bus.mem_req_valid = (state == S_REQ);
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_wstrb = wstrb_q;
    assign bus.if_rsp_valid  = if_rsp_vld_p1;
    assign bus.if_rsp_rdata  = if_rdata_p1;
    assign bus.ls_rsp_valid  = ls_rsp_vld_p1;
    assign bus.ls_rsp_rdata  = ls_rdata_p1;
    assign bus.busy          = (state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, cycle-exact bench for mem_port_arbiter; memory handshakes are driven by hand.
// Expectations follow ARB_RR_EN when the bench is built with that macro.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
        bus.ls_req_valid = 1'b0; bus.ls_req_addr = '0; bus.ls_req_we = 1'b0;
        bus.ls_req_wdata = '0;   bus.ls_req_wstrb = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        tests_run++; if (bus.mem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_req_valid); end
        tests_run++; if (bus.mem_req_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_req_addr); end
        tests_run++; if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b%b exp=00", bus.if_rsp_valid, bus.ls_rsp_valid); end
        tests_run++; if (bus.if_req_ready !== 1'b0 || bus.ls_req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_readys got=%b%b exp=00", bus.if_req_ready, bus.ls_req_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_if_fetch;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h100; bus.mem_req_ready = 1'b1;
        #1;
        tests_run++; if (bus.if_req_ready !== 1'b1 || bus.ls_req_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_ready got=%b%b exp=10", bus.if_req_ready, bus.ls_req_ready); end
        step();
        bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
        #1;
        tests_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100) begin tests_failed++; $display("FAIL fetch_mem_req got=%b/%h exp=1/00000100", bus.mem_req_valid, bus.mem_req_addr); end
        tests_run++; if (bus.mem_req_we !== 1'b0 || bus.mem_req_wstrb !== 4'h0) begin tests_failed++; $display("FAIL fetch_mem_we got=%b/%h exp=0/0", bus.mem_req_we, bus.mem_req_wstrb); end
        tests_run++; if (bus.busy !== 1'b1 || bus.if_req_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_busy got=%b ready=%b exp=1/0", bus.busy, bus.if_req_ready); end
        step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h00500093;
        #1;
        tests_run++; if (bus.mem_req_valid !== 1'b0 || bus.if_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL fetch_wait got=%b/%b exp=0/0", bus.mem_req_valid, bus.if_rsp_valid); end
        step();
        bus.mem_rsp_valid = 1'b0;
        tests_run++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_rdata !== 32'h00500093) begin tests_failed++; $display("FAIL fetch_rsp got=%b/%h exp=1/00500093", bus.if_rsp_valid, bus.if_rsp_rdata); end
        tests_run++; if (bus.ls_rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL fetch_other got=ls%b busy%b exp=0/0", bus.ls_rsp_valid, bus.busy); end
        step();
        tests_run++; if (bus.if_rsp_valid !== 1'b0 || bus.if_rsp_rdata !== 32'h00500093) begin tests_failed++; $display("FAIL fetch_pulse_hold got=%b/%h exp=0/00500093", bus.if_rsp_valid, bus.if_rsp_rdata); end
    endtask

    task automatic test_arbitration;
        int         n;
        logic [3:0] exp_ls_v;
        logic       keep_ls;
        logic       e;
        logic [31:0] exp_addr;
        rst = 1'b1; #1; rst = 1'b0;
        step();
`ifdef ARB_RR_EN
        n = 4; exp_ls_v = 4'b0101; keep_ls = 1'b1;
`else
        n = 2; exp_ls_v = 4'b0001; keep_ls = 1'b0;
`endif
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h104;
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h2000; bus.ls_req_we = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = exp_ls_v[i];
            #1;
            tests_run++; if (bus.ls_req_ready !== e || bus.if_req_ready !== !e) begin tests_failed++; $display("FAIL arb_grant%0d got=ls%b if%b exp=ls%b", i, bus.ls_req_ready, bus.if_req_ready, e); end
            step();
            if (e && !keep_ls) bus.ls_req_valid = 1'b0;
            if (i == n - 1) begin bus.ls_req_valid = 1'b0; bus.if_req_valid = 1'b0; end
            exp_addr = e ? 32'h2000 : 32'h104;
            tests_run++; if (bus.mem_req_addr !== exp_addr || bus.mem_req_we !== 1'b0) begin tests_failed++; $display("FAIL arb_addr%0d got=%h/%b exp=%h/0", i, bus.mem_req_addr, bus.mem_req_we, exp_addr); end
            step();
            bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hA0 + i;
            step();
            bus.mem_rsp_valid = 1'b0;
            if (e) begin
                tests_run++; if (bus.ls_rsp_valid !== 1'b1 || bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_rdata !== 32'hA0 + i) begin tests_failed++; $display("FAIL arb_rsp%0d got=ls%b if%b %h exp=ls1 if0 %h", i, bus.ls_rsp_valid, bus.if_rsp_valid, bus.ls_rsp_rdata, 32'hA0 + i); end
            end else begin
                tests_run++; if (bus.if_rsp_valid !== 1'b1 || bus.ls_rsp_valid !== 1'b0 || bus.if_rsp_rdata !== 32'hA0 + i) begin tests_failed++; $display("FAIL arb_rsp%0d got=if%b ls%b %h exp=if1 ls0 %h", i, bus.if_rsp_valid, bus.ls_rsp_valid, bus.if_rsp_rdata, 32'hA0 + i); end
            end
        end
        step();
        tests_run++; if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL arb_end got=if%b ls%b busy%b exp=000", bus.if_rsp_valid, bus.ls_rsp_valid, bus.busy); end
    endtask

    task automatic test_store;
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h3004; bus.ls_req_we = 1'b1;
        bus.ls_req_wdata = 32'hDEADBEEF; bus.ls_req_wstrb = 4'b0011; bus.mem_req_ready = 1'b1;
        #1;
        tests_run++; if (bus.ls_req_ready !== 1'b1 || bus.if_req_ready !== 1'b0) begin tests_failed++; $display("FAIL store_ready got=ls%b if%b exp=ls1 if0", bus.ls_req_ready, bus.if_req_ready); end
        step();
        bus.ls_req_valid = 1'b0; bus.ls_req_addr = '0; bus.ls_req_we = 1'b0; bus.ls_req_wdata = '0; bus.ls_req_wstrb = '0;
        #1;
        tests_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h3004 || bus.mem_req_we !== 1'b1) begin tests_failed++; $display("FAIL store_req got=%b/%h/%b exp=1/00003004/1", bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we); end
        tests_run++; if (bus.mem_req_wdata !== 32'hDEADBEEF || bus.mem_req_wstrb !== 4'b0011) begin tests_failed++; $display("FAIL store_data got=%h/%b exp=deadbeef/0011", bus.mem_req_wdata, bus.mem_req_wstrb); end
        step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h12345678;
        #1;
        tests_run++; if (bus.ls_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL store_early_rsp got=%b exp=0", bus.ls_rsp_valid); end
        step();
        bus.mem_rsp_valid = 1'b0;
        tests_run++; if (bus.ls_rsp_valid !== 1'b1 || bus.ls_rsp_rdata !== 32'h12345678) begin tests_failed++; $display("FAIL store_rsp got=%b/%h exp=1/12345678", bus.ls_rsp_valid, bus.ls_rsp_rdata); end
        tests_run++; if (bus.if_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL store_if_rsp got=%b exp=0", bus.if_rsp_valid); end
        step();
    endtask

    task automatic test_stall;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h200; bus.mem_req_ready = 1'b0;
        #1;
        step();
        bus.if_req_valid = 1'b0;
        bus.ls_req_valid = 1'b1; bus.ls_req_addr = 32'h5000; bus.ls_req_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.mem_rsp_valid = (k == 1); bus.mem_rsp_rdata = 32'hBAD0BAD0;
            #1;
            tests_run++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h200 || bus.mem_req_we !== 1'b0) begin tests_failed++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/00000200/0", k, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we); end
            tests_run++; if (bus.ls_req_ready !== 1'b0 || bus.if_req_ready !== 1'b0 || bus.busy !== 1'b1) begin tests_failed++; $display("FAIL stall_ctl%0d got=ls%b if%b busy%b exp=0/0/1", k, bus.ls_req_ready, bus.if_req_ready, bus.busy); end
            tests_run++; if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_rsp%0d got=if%b ls%b exp=00", k, bus.if_rsp_valid, bus.ls_rsp_valid); end
            step();
        end
        bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b1; bus.ls_req_valid = 1'b0;
        step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h00000213;
        step();
        bus.mem_rsp_valid = 1'b0;
        tests_run++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_rdata !== 32'h00000213 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL stall_done got=%b/%h busy%b exp=1/00000213/0", bus.if_rsp_valid, bus.if_rsp_rdata, bus.busy); end
        step();
    endtask

    task automatic test_reset_abort;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h300; bus.mem_req_ready = 1'b1;
        #1;
        step();
        bus.if_req_valid = 1'b0;
        step();
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL abort_in_wait got=%b exp=1", bus.busy); end
        rst = 1'b1;
        #1;
        tests_run++; if (bus.busy !== 1'b0 || bus.mem_req_addr !== 32'h0 || bus.if_rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL abort_clear got=busy%b %h %h exp=0/0/0", bus.busy, bus.mem_req_addr, bus.if_rsp_rdata); end
        step();
        rst = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'h00BADBAD;
        step();
        bus.mem_rsp_valid = 1'b0;
        tests_run++; if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_late_rsp got=if%b ls%b busy%b exp=000", bus.if_rsp_valid, bus.ls_rsp_valid, bus.busy); end
        step();
        tests_run++; if (bus.if_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_late_rsp2 got=%b exp=0", bus.if_rsp_valid); end
        bus.if_req_valid = 1'b1; bus.if_req_addr = 32'h400;
        #1;
        tests_run++; if (bus.if_req_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_next_ready got=%b exp=1", bus.if_req_ready); end
        step();
        bus.if_req_valid = 1'b0;
        tests_run++; if (bus.mem_req_addr !== 32'h400 || bus.mem_req_valid !== 1'b1) begin tests_failed++; $display("FAIL abort_next_req got=%h/%b exp=00000400/1", bus.mem_req_addr, bus.mem_req_valid); end
        step();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hCAFEF00D;
        step();
        bus.mem_rsp_valid = 1'b0;
        tests_run++; if (bus.if_rsp_valid !== 1'b1 || bus.if_rsp_rdata !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL abort_next_rsp got=%b/%h exp=1/cafef00d", bus.if_rsp_valid, bus.if_rsp_rdata); end
        step();
    endtask

    task automatic test_idle_rsp;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hFFFFFFFF;
        #1;
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_rsp_busy got=%b exp=0", bus.busy); end
        step();
        bus.mem_rsp_valid = 1'b0;
        tests_run++; if (bus.if_rsp_valid !== 1'b0 || bus.ls_rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_rsp_pulse got=if%b ls%b busy%b exp=000", bus.if_rsp_valid, bus.ls_rsp_valid, bus.busy); end
        tests_run++; if (bus.if_rsp_rdata !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL idle_rsp_hold got=%h exp=cafef00d", bus.if_rsp_rdata); end
        step();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_if_fetch();
        test_arbitration();
        test_store();
        test_stall();
        test_reset_abort();
        test_idle_rsp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
